alu_cmp_seq: RTL

- Parametrised multi-cycle compare unit producing the 1-bit set/branch condition `s` for the CPU's compare-class ALU functions.
- Operates directly on two WIDTH-bit operands: computes equality, signed and unsigned less-than itself, with no external flags.
- Scans CHUNK bits per cycle from MSB down, with early exit on the first differing chunk.
- Sits beside the ALU adder behind a valid/ready handshake so the issue stage can stall on it.

---
 rtl/alu_cmp_pkg.sv | 43 ++++
 rtl/alu_cmp_chunk.sv | 18 +
 rtl/alu_cmp_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_cmp_pkg.sv
// alu_cmp_pkg: shared definitions for the multi-cycle compare unit.
//   - fun codes (CMP_NE .. CMP_GTZ)
//   - FSM state encoding (ST_IDLE, ST_SCAN, ST_DONE)
//   - helpers: is_signed, is_zero_cmp, map_s (final lt/eq -> s)
package alu_cmp_pkg;

  localparam logic [2:0] CMP_NE  = 3'b000;
  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b010;
  localparam logic [2:0] CMP_LTU = 3'b011;
  localparam logic [2:0] CMP_GEZ = 3'b100;
  localparam logic [2:0] CMP_LTZ = 3'b101;
  localparam logic [2:0] CMP_LEZ = 3'b110;
  localparam logic [2:0] CMP_GTZ = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_signed(input logic [2:0] fun);
    return fun[2] | (fun == CMP_LT);
  endfunction

  function automatic logic is_zero_cmp(input logic [2:0] fun);
    return fun[2];
  endfunction

  function automatic logic map_s(input logic [2:0] fun, input logic lt, input logic eq);
    logic r;
    case (fun)
      CMP_NE:  r = ~eq;
      CMP_EQ:  r = eq;
      CMP_GEZ: r = ~lt;
      CMP_LEZ: r = lt | eq;
      CMP_GTZ: r = ~(lt | eq);
      default: r = lt;  // LT, LTU, LTZ
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_cmp_chunk.sv
// alu_cmp_chunk: unsigned compare of one CHUNK-bit slice pair.
// Ports:
//   a, b : CHUNK-bit slices of the two (pre-conditioned) operands
//   lt   : a < b (unsigned)
//   eq   : a == b
module alu_cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq
);

  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/alu_cmp_seq.sv
// alu_cmp_seq: multi-cycle compare unit producing the set/branch bit s.
// Scans CHUNK bits per cycle from the MSB chunk down, exiting on the first
// differing chunk. Signed functions flip both operand MSBs at capture so the
// unsigned chunk scan yields signed order.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : request handshake (in_ready only in IDLE)
//   a, b, fun            : operands and compare function
//   out_valid / out_ready: result handshake, s held while stalled
//   s                    : compare result
//   busy                 : high in SCAN or DONE
// Build option: ALU_CMP_FIXED_LAT_EN disables early exit; every operation
// visits all chunks, giving a constant latency of WIDTH/CHUNK.
module alu_cmp_seq
  import alu_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8   // WIDTH must be a multiple of CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       fun,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a, op_b;
  logic [2:0]       fun_q;
  logic [IDXW-1:0]  idx;
  logic             lt, eq;

  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CHUNK-1:0] sl_a, sl_b;
  logic             c_lt, c_eq;
  logic             lt_n, eq_n, done_n;

  assign sh_a = op_a >> (int'(idx) * CHUNK);
  assign sh_b = op_b >> (int'(idx) * CHUNK);
  assign sl_a = sh_a[CHUNK-1:0];
  assign sl_b = sh_b[CHUNK-1:0];

  alu_cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (sl_a),
    .b  (sl_b),
    .lt (c_lt),
    .eq (c_eq)
  );

  // eq tracks "all chunks so far equal" and starts at 1 on capture, so the
  // first differing chunk latches lt and later chunks can never overwrite it.
  // With early exit eq is always 1 while scanning, so the same update serves
  // both builds; only the exit condition differs.
  always_comb begin
    eq_n = eq & c_eq;
    lt_n = eq ? c_lt : lt;
`ifdef ALU_CMP_FIXED_LAT_EN
    done_n = (idx == '0);
`else
    done_n = ~c_eq | (idx == '0);
`endif
  end

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      fun_q     <= '0;
      idx       <= '0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      s         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_a  <= is_signed(fun) ? (a ^ MSB_MASK) : a;
            op_b  <= (is_zero_cmp(fun) ? '0 : b) ^ (is_signed(fun) ? MSB_MASK : '0);
            fun_q <= fun;
            idx   <= IDXW'(NCHUNK - 1);
            lt    <= 1'b0;
            eq    <= 1'b1;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          lt <= lt_n;
          eq <= eq_n;
          if (done_n) begin
            s         <= map_s(fun_q, lt_n, eq_n);
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
